// File: rtl/lcd_spi_rx.sv
// SPI mode-0 slave receiver for the LCD write link (cs, dc, sclk, mosi).
// Recovers 9-bit {dc, byte} words MSB first and queues them in a small FWFT FIFO
// whose head is held in a register.
module lcd_spi_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       cs,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       dc,
  output logic [8:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_err,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {StIdle, StShift} state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q, dc_sync_q, vld_sync_q;
  logic                   cs_prev_q, sclk_prev_q, armed_q;
  logic                   cs_s, sclk_s, mosi_s, dc_s;
  logic                   sclk_rise, cs_rise, cs_fall;

  state_e      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [6:0]  shreg_q, shreg_d;
  logic        push_q, push_d;
  logic [8:0]  push_word_q, push_word_d;
  logic        err_d;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [8:0]    head_d;
  logic          full, pop, wr_en, ovf_set;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s   = dc_sync_q[SYNC_STAGES-1];

  // A cs fall only counts once a genuine high level has been seen after reset, so the
  // reset value of the cs chain draining into a held-low cs cannot start a frame.
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = armed_q & cs_prev_q & ~cs_s;

  // Input synchronisers, previous-value registers for edge detection and cs arming.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
      vld_sync_q  <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], dc};
      vld_sync_q  <= {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      armed_q     <= armed_q | (vld_sync_q[SYNC_STAGES-1] & cs_s);
    end
  end

  // Receive FSM state, bit counter, shift register and registered push request.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      rx_err      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      rx_err      <= err_d;
    end
  end

  // Next-state: shift on sclk rise first, then judge a cs release against the new count.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    err_d       = 1'b0;
    case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d  = StShift;
          bitcnt_d = '0;
          shreg_d  = '0;
        end
      end
      StShift: begin
        if (sclk_rise) begin
          shreg_d  = {shreg_q[5:0], mosi_s};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            push_d      = 1'b1;
            push_word_d = {dc_s, shreg_q, mosi_s};
          end
        end
        if (cs_rise) begin
          state_d = StIdle;
          err_d   = (bitcnt_d != 3'd0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO control; a push into a full FIFO still lands if the head pops the same cycle.
  always_comb begin
    full     = (count_q == CW'(FIFO_DEPTH));
    pop      = rx_valid & rx_ready;
    wr_en    = push_q & (~full | pop);
    ovf_set  = push_q & full & ~pop;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(pop);
    head_d   = rx_data;
    if (count_d != '0) begin
      head_d = (wr_en && (wr_ptr_q == rd_ptr_d)) ? push_word_q : mem_q[rd_ptr_d];
    end
  end

  // FIFO storage; contents are only observed through the head register.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_word_q;
    end
  end

  // FIFO pointers, registered head/valid and sticky overflow (set beats clear).
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rx_data  <= head_d;
      rx_valid <= (count_d != '0);
      overflow <= ovf_set | (overflow & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Scoreboard bench for lcd_spi_rx: stimulus pushes expected words, a monitor pops them.
module tb_lcd_spi_rx;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       cs = 1'b1, sclk = 1'b0, mosi = 1'b0, dc = 1'b0;
  logic [8:0] rx_data;
  logic       rx_valid, rx_ready = 1'b0, rx_err, overflow, ovf_clr = 1'b0;

  int         n_vec = 0, n_miss = 0;
  int         exp_err = 0, err_seen = 0;
  logic       err_prev = 1'b0;
  bit         rand_rdy = 1'b0;
  logic [8:0] exp_q[$];
  logic [7:0] tx_bytes[$];

  lcd_spi_rx #(.SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .cs      (cs),
    .sclk    (sclk),
    .mosi    (mosi),
    .dc      (dc),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_err  (rx_err),
    .overflow(overflow),
    .ovf_clr (ovf_clr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      wait_clk(lo);
      sclk = 1'b1;
      wait_clk(hi);
      sclk = 1'b0;
    end
  endtask

  // Reference model: every complete 8 bits in a cs window is one {dc, byte} word (only the
  // first 'keep' are expected to survive), leftover bits at cs release are one error.
  task automatic frame(input bit dcv, input int keep, input int extra, input int hi,
                       input int lo);
    dc = dcv;
    cs = 1'b0;
    wait_clk(3);
    foreach (tx_bytes[k]) begin
      if (k < keep) exp_q.push_back({dcv, tx_bytes[k]});
      send_bits(tx_bytes[k], 8, hi, lo);
    end
    if (extra > 0) begin
      send_bits(8'($urandom), extra, hi, lo);
      exp_err++;
    end
    wait_clk(3);
    cs = 1'b1;
    wait_clk(6);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) wait_clk(1);
    chk(name, exp_q.size(), 0);
  endtask

  // Randomised consumer when enabled.
  initial begin
    forever begin
      @(posedge sys_clk);
      #2;
      if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pop scoreboard on every accepted word; count and width-check rx_err pulses.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (!sys_rst && rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_word: got %0h expected none", rx_data);
        end else begin
          chk("rx_word", rx_data, exp_q.pop_front());
        end
      end
      if (rx_err) begin
        err_seen++;
        chk("rx_err_one_cycle", err_prev, 0);
      end
      err_prev = rx_err;
    end
  end

  initial begin
    int lat;
    wait_clk(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_err", rx_err, 0);
    chk("rst_ovf", overflow, 0);
    sys_rst = 1'b0;
    wait_clk(4);

    // 1: single command byte 0x2A with latency measurement on the 8th rise.
    dc = 1'b0;
    cs = 1'b0;
    wait_clk(3);
    exp_q.push_back(9'h02A);
    send_bits(8'h2A, 7, 2, 2);
    mosi = 1'b0;
    wait_clk(2);
    sclk = 1'b1;
    lat = 0;
    while (!rx_valid && lat < 10) begin
      wait_clk(1);
      lat++;
    end
    chk("t1_latency", lat, 4);
    sclk = 1'b0;
    wait_clk(3);
    cs = 1'b1;
    wait_clk(6);
    chk("t1_head", rx_data, 9'h02A);
    chk("t1_err", err_seen, exp_err);
    rand_rdy = 1'b1;
    drain("t1_drain");

    // 2: three data bytes in one window at minimum timing.
    tx_bytes = '{8'hF8, 8'h1F, 8'h00};
    frame(1'b1, 3, 0, 2, 2);
    drain("t2_drain");
    chk("t2_err", err_seen, exp_err);

    // 3: 5-bit partial frame, then a clean 0x55.
    rand_rdy = 1'b0;
    rx_ready = 1'b0;
    tx_bytes = {};
    frame(1'b0, 0, 5, 2, 2);
    chk("t3_err", err_seen, exp_err);
    chk("t3_fifo_empty", rx_valid, 0);
    tx_bytes = '{8'h55};
    frame(1'b0, 1, 0, 3, 2);
    rand_rdy = 1'b1;
    drain("t3_drain");

    // 4: overflow with consumer stalled, clear, then drain.
    rand_rdy = 1'b0;
    wait_clk(1);
    rx_ready = 1'b0;
    tx_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    frame(1'b0, 4, 0, 2, 2);
    chk("t4_ovf_set", overflow, 1);
    ovf_clr = 1'b1;
    wait_clk(1);
    ovf_clr = 1'b0;
    wait_clk(1);
    chk("t4_ovf_clr", overflow, 0);
    chk("t4_fifo_kept", rx_valid, 1);
    rand_rdy = 1'b1;
    drain("t4_drain");
    rand_rdy = 1'b0;
    wait_clk(2);
    rx_ready = 1'b0;
    chk("t4_empty", rx_valid, 0);

    // 5: full FIFO, pop lands on the same cycle as the 5th push.
    tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    frame(1'b1, 4, 0, 2, 2);
    dc = 1'b1;
    cs = 1'b0;
    wait_clk(3);
    exp_q.push_back(9'h1C3);
    send_bits(8'hC3, 7, 2, 2);
    mosi = 1'b1;
    wait_clk(2);
    sclk = 1'b1;
    wait_clk(3);
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    wait_clk(1);
    sclk = 1'b0;
    wait_clk(3);
    cs = 1'b1;
    wait_clk(6);
    chk("t5_no_ovf", overflow, 0);
    rand_rdy = 1'b1;
    drain("t5_drain");

    // 6: reset mid-byte with cs held low, then a fresh frame.
    rand_rdy = 1'b0;
    wait_clk(1);
    rx_ready = 1'b0;
    dc = 1'b0;
    cs = 1'b0;
    wait_clk(3);
    send_bits(8'hA5, 4, 2, 2);
    wait_clk(1);
    sys_rst = 1'b1;
    wait_clk(2);
    chk("t6_rst_data", rx_data, 0);
    sys_rst = 1'b0;
    wait_clk(2);
    send_bits(8'h50, 4, 2, 2);
    wait_clk(3);
    cs = 1'b1;
    wait_clk(6);
    chk("t6_nothing", rx_valid, 0);
    chk("t6_err", err_seen, exp_err);
    tx_bytes = '{8'hA5};
    frame(1'b0, 1, 0, 2, 2);
    rand_rdy = 1'b1;
    drain("t6_drain");

    // Random frames against the model.
    for (int f = 0; f < 25; f++) begin
      int nb, extra;
      nb = $urandom_range(0, 3);
      tx_bytes = {};
      for (int k = 0; k < nb; k++) tx_bytes.push_back(8'($urandom));
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      frame(1'($urandom_range(0, 1)), nb, extra, $urandom_range(2, 4), $urandom_range(2, 4));
    end
    drain("rand_drain");
    chk("rand_err", err_seen, exp_err);
    chk("rand_ovf", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
